// File: rtl/pll_lock_reset_seq.sv
// Lock-qualified reset sequencer running in the PLL output clock domain.
// Synchronises the raw PLL LOCK flag and waits for a run of consecutive locked
// cycles. It then releases the domain resets one at a time, bit 0 first, with a
// fixed stagger, and reasserts every domain reset at once when lock is lost.
// It also keeps a saturating lock-loss count and drives a heartbeat that runs
// only while the system is ready.
module pll_lock_reset_seq #(
   parameter int SYNC_STAGES      = 2,
   parameter int LOCK_QUAL_CYCLES = 1024,
   parameter int STAGGER_CYCLES   = 16,
   parameter int NUM_DOMAINS      = 4,
   parameter int HB_DIV_BITS      = 26,
   parameter int CNT_WIDTH        = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_pll_locked,
   output logic [NUM_DOMAINS-1:0] o_domain_rst,
   output logic                   o_ready,
   output logic [1:0]             o_state,
   output logic [CNT_WIDTH-1:0]   o_lock_loss_count,
   output logic                   o_heartbeat
);

   // One spare bit so neither counter can wrap inside its phase.
   localparam int QW = $clog2(LOCK_QUAL_CYCLES) + 1;
   localparam int SW = $clog2(STAGGER_CYCLES) + 1;
   localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_QUAL_CYCLES - 1);
   localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      QUALIFY   = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   w_lock_s;
   logic [QW-1:0]          qual_cnt_q, qual_cnt_d;
   logic [SW-1:0]          stag_cnt_q, stag_cnt_d;
   logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
   logic                   ready_q, ready_d;
   logic [CNT_WIDTH-1:0]   loss_cnt_q, loss_cnt_d;
   logic [HB_DIV_BITS-1:0] hb_cnt_q, hb_cnt_d;

   assign w_lock_s = sync_q[SYNC_STAGES-1];

   // Multi-flop synchroniser for the asynchronous LOCK flag.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples
         // the pre-edge value of its neighbour, as real hardware does.
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_pll_locked};
      end
   end

   // State, counters and output registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= WAIT_LOCK;
         qual_cnt_q <= '0;
         stag_cnt_q <= '0;
         dom_rst_q  <= '1;
         ready_q    <= 1'b0;
         loss_cnt_q <= '0;
         hb_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         qual_cnt_q <= qual_cnt_d;
         stag_cnt_q <= stag_cnt_d;
         dom_rst_q  <= dom_rst_d;
         ready_q    <= ready_d;
         loss_cnt_q <= loss_cnt_d;
         hb_cnt_q   <= hb_cnt_d;
      end
   end

   // Next-state logic: qualification, staggered release and lock-loss handling.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      qual_cnt_d = qual_cnt_q;
      stag_cnt_d = stag_cnt_q;
      dom_rst_d  = dom_rst_q;
      ready_d    = ready_q;
      loss_cnt_d = loss_cnt_q;

      unique case (state_q)
         WAIT_LOCK: begin
            qual_cnt_d = '0;
            stag_cnt_d = '0;
            dom_rst_d  = '1;
            ready_d    = 1'b0;
            if (w_lock_s) state_d = QUALIFY;
         end
         QUALIFY: begin
            if (!w_lock_s) begin
               // A glitch during qualification is not a counted loss.
               state_d    = WAIT_LOCK;
               qual_cnt_d = '0;
            end else if (qual_cnt_q == QUAL_LAST) begin
               state_d    = RELEASE;
               qual_cnt_d = '0;
               stag_cnt_d = '0;
               dom_rst_d  = dom_rst_q << 1;
            end else begin
               qual_cnt_d = qual_cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (!w_lock_s) begin
               state_d    = WAIT_LOCK;
               dom_rst_d  = '1;
               ready_d    = 1'b0;
               stag_cnt_d = '0;
               if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
            end else if (stag_cnt_q == STAG_LAST) begin
               stag_cnt_d = '0;
               // Once every bit is low, one more stagger period leads into RUN.
               if (dom_rst_q == '0) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end else begin
                  dom_rst_d = dom_rst_q << 1;
               end
            end else begin
               stag_cnt_d = stag_cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!w_lock_s) begin
               state_d    = WAIT_LOCK;
               dom_rst_d  = '1;
               ready_d    = 1'b0;
               stag_cnt_d = '0;
               if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
            end
         end
      endcase

      // Heartbeat counts only while ready stays high, so it clears on the
      // same edge that ready drops and never shows a stale MSB.
      hb_cnt_d = (ready_q && ready_d) ? hb_cnt_q + 1'b1 : '0;
   end

   assign o_domain_rst      = dom_rst_q;
   assign o_ready           = ready_q;
   assign o_state           = state_q;
   assign o_lock_loss_count = loss_cnt_q;
   assign o_heartbeat       = hb_cnt_q[HB_DIV_BITS-1];

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed phases with literal expectations,
// then randomized lock patterns, all compared every cycle against a
// closed-form model of the release schedule.
module tb_pll_lock_reset_seq;

   localparam int SYNC = 2;
   localparam int L    = 8;
   localparam int S    = 4;
   localparam int N    = 3;
   localparam int HB   = 4;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_pll_locked = 1'b0;

   logic [N-1:0] rst_a, rst_b;
   logic         rdy_a, rdy_b;
   logic [1:0]   st_a, st_b;
   logic [7:0]   cnt_a;
   logic [1:0]   cnt_b;
   logic         hb_a, hb_b;

   int checks = 0;
   int failures = 0;

   // Model state
   int        edge_n;
   bit        hist[$];
   bit        q_valid;
   int        q_edge;
   int        m_loss;
   logic [N-1:0] m_rst;
   logic      m_ready;
   logic [1:0] m_state;
   logic      m_hb;

   pll_lock_reset_seq #(
      .SYNC_STAGES(SYNC), .LOCK_QUAL_CYCLES(L), .STAGGER_CYCLES(S),
      .NUM_DOMAINS(N), .HB_DIV_BITS(HB), .CNT_WIDTH(8)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_pll_locked(i_pll_locked),
      .o_domain_rst(rst_a), .o_ready(rdy_a), .o_state(st_a),
      .o_lock_loss_count(cnt_a), .o_heartbeat(hb_a)
   );

   pll_lock_reset_seq #(
      .SYNC_STAGES(SYNC), .LOCK_QUAL_CYCLES(L), .STAGGER_CYCLES(S),
      .NUM_DOMAINS(N), .HB_DIV_BITS(HB), .CNT_WIDTH(2)
   ) dut_sat (
      .i_clk(i_clk), .i_reset(i_reset), .i_pll_locked(i_pll_locked),
      .o_domain_rst(rst_b), .o_ready(rdy_b), .o_state(st_b),
      .o_lock_loss_count(cnt_b), .o_heartbeat(hb_b)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
      end
   endtask

   // Behavioural model: outputs follow from how long the synchronised lock
   // has been continuously high since qualification started.
   always @(posedge i_clk or posedge i_reset) begin
      int  d;
      bit  s;
      if (i_reset) begin
         edge_n  = 0;
         hist.delete();
         q_valid = 1'b0;
         m_loss  = 0;
      end else begin
         edge_n++;
         s = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : 1'b0;
         hist.push_back(i_pll_locked);
         if (hist.size() > 8) void'(hist.pop_front());
         if (!q_valid) begin
            if (s) begin
               q_valid = 1'b1;
               q_edge  = edge_n;
            end
         end else if (!s) begin
            // Counted only if the state before this edge was RELEASE or RUN.
            if (edge_n - q_edge > L) m_loss++;
            q_valid = 1'b0;
         end
      end
      m_rst = '1; m_ready = 1'b0; m_state = 2'd0; m_hb = 1'b0;
      if (q_valid) begin
         d = edge_n - q_edge;
         if (d < L) begin
            m_state = 2'd1;
         end else if (d >= L + N*S) begin
            m_state = 2'd3;
            m_ready = 1'b1;
            m_rst   = '0;
            m_hb    = ((d - (L + N*S)) >> (HB-1)) & 1;
         end else begin
            m_state = 2'd2;
            for (int k = 0; k < N; k++) m_rst[k] = !(d >= L + k*S);
         end
      end
   end

   // Compare both instances against the model on every falling edge.
   always @(negedge i_clk) begin
      if (!i_reset) begin
         check("rst",      rst_a, m_rst);
         check("ready",    rdy_a, m_ready);
         check("state",    st_a,  m_state);
         check("count8",   cnt_a, (m_loss > 255) ? 255 : m_loss);
         check("hb",       hb_a,  m_hb);
         check("sat_rst",  rst_b, m_rst);
         check("sat_st",   st_b,  m_state);
         check("count2",   cnt_b, (m_loss > 3) ? 3 : m_loss);
      end
   end

   task automatic step_to(input int n);
      while (edge_n < n) @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      bit lvl;
      int len;
      i_pll_locked = 1'b1;
      do_reset();

      // Release sequence with lock held: Q=3, E=11, RUN at 23.
      step_to(10);
      check("lit_qual_state", st_a, 2'd1);
      check("lit_qual_rst", rst_a, 3'b111);
      step_to(11);
      check("lit_E_rst", rst_a, 3'b110);
      check("lit_E_state", st_a, 2'd2);
      step_to(15);
      check("lit_E4_rst", rst_a, 3'b100);
      step_to(22);
      check("lit_pre_run_rst", rst_a, 3'b000);
      check("lit_pre_run_ready", rdy_a, 1'b0);
      step_to(23);
      check("lit_run_ready", rdy_a, 1'b1);
      check("lit_run_state", st_a, 2'd3);
      step_to(30);
      check("lit_hb_low", hb_a, 1'b0);
      step_to(31);
      check("lit_hb_rise", hb_a, 1'b1);
      step_to(39);
      check("lit_hb_fall", hb_a, 1'b0);

      // Glitch during qualification.
      do_reset();
      step_to(6);
      i_pll_locked = 1'b0;
      step_to(7);
      i_pll_locked = 1'b1;
      step_to(8);
      check("lit_glitch_pre", st_a, 2'd1);
      step_to(9);
      check("lit_glitch_state", st_a, 2'd0);
      check("lit_glitch_rst", rst_a, 3'b111);
      check("lit_glitch_cnt", cnt_a, 8'd0);
      step_to(17);
      check("lit_requal_state", st_a, 2'd1);
      step_to(18);
      check("lit_requal_rst", rst_a, 3'b110);

      // Loss in RUN (RUN at 30).
      step_to(35);
      i_pll_locked = 1'b0;
      step_to(37);
      check("lit_run_hold", rdy_a, 1'b1);
      step_to(38);
      check("lit_loss_rst", rst_a, 3'b111);
      check("lit_loss_ready", rdy_a, 1'b0);
      check("lit_loss_hb", hb_a, 1'b0);
      check("lit_loss_cnt", cnt_a, 8'd1);
      check("lit_loss_state", st_a, 2'd0);
      i_pll_locked = 1'b1;

      // Loss in RELEASE (Q=41, E=49).
      step_to(49);
      i_pll_locked = 1'b0;
      step_to(51);
      check("lit_rel_rst", rst_a, 3'b110);
      step_to(52);
      check("lit_rel_loss_rst", rst_a, 3'b111);
      check("lit_rel_loss_cnt", cnt_a, 8'd2);
      i_pll_locked = 1'b1;
      step_to(63);
      check("lit_rel_again", rst_a, 3'b110);

      // Asynchronous reset between edges during RELEASE.
      step_to(65);
      #2 i_reset = 1'b1;
      #1;
      check("lit_async_rst", rst_a, 3'b111);
      check("lit_async_ready", rdy_a, 1'b0);
      check("lit_async_state", st_a, 2'd0);
      check("lit_async_cnt", cnt_a, 8'd0);
      check("lit_async_hb", hb_a, 1'b0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;

      // Five RUN-state losses: 8-bit count reaches 5, 2-bit count saturates.
      for (int i = 0; i < 5; i++) begin
         repeat (40) @(negedge i_clk);
         i_pll_locked = 1'b0;
         repeat (3) @(negedge i_clk);
         i_pll_locked = 1'b1;
      end
      repeat (5) @(negedge i_clk);
      check("lit_sat_cnt8", cnt_a, 8'd5);
      check("lit_sat_cnt2", cnt_b, 2'b11);

      // Randomized lock patterns.
      lvl = 1'b1;
      for (int seg = 0; seg < 80; seg++) begin
         lvl = ~lvl;
         len = lvl ? $urandom_range(1, 40) : $urandom_range(1, 6);
         i_pll_locked = lvl;
         repeat (len) @(negedge i_clk);
      end
      repeat (5) @(negedge i_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
